// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin sharing of one fixed-latency, non-stallable multiplier among N requesters
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (req_ready is one-hot grant)
//   req_a/req_b              packed operands, requester i at [i*W +: W]
//   mul_a/mul_b/mul_product  registered operands to / result from the external multiplier
//   rsp_valid/rsp_ready      response handshake from the result FIFO head
//   rsp_id/rsp_product       originating requester and product of the head entry
//   busy                     operations issued but not yet returned
module mult_share_ctrl #(
    parameter int W          = 16,
    parameter int N          = 4,
    parameter int LAT        = 9,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*W-1:0]       req_a,
    input  logic [N*W-1:0]       req_b,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-1:0]       mul_product,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [2*W-1:0]       rsp_product,
    output logic                 busy
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;

    logic [CW-1:0]      c_q, c_d, cnt_q, cnt_d;
    logic [IW-1:0]      last_q, gid, cand;
    logic [W-1:0]       a_q, b_q, sel_a, sel_b;
    logic               found, can_grant, issue, push, pop;
    logic               vld_q [LAT+1];
    logic [IW-1:0]      id_q  [LAT+1];
    logic [PW-1:0]      wr_q, rd_q;
    logic [IW+2*W-1:0]  mem   [FIFO_DEPTH];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search starting just after the last winner.
    always_comb begin
        found = 1'b0;
        gid   = '0;
        cand  = last_q;
        for (int k = 0; k < N; k++) begin
            cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gid   = cand;
            end
        end
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (gid == IW'(i)) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    // Grant only uses registered credit state, so rsp_ready never reaches req_ready.
    assign can_grant = !rst && (c_q != CW'(FIFO_DEPTH));
    assign issue     = found && can_grant;
    assign req_ready = issue ? (N'(1) << gid) : '0;
    assign rsp_valid = cnt_q != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign push      = vld_q[LAT];
    assign c_d       = c_q + CW'(issue) - CW'(pop);
    assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign busy      = c_q != '0;
    assign {rsp_id, rsp_product} = mem[rd_q];

    // Issue register is stage 0 of the ID line; stage LAT lines up with mul_product.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            last_q <= IW'(N - 1);
            c_q    <= '0;
            for (int k = 0; k <= LAT; k++) vld_q[k] <= 1'b0;
        end else begin
            c_q      <= c_d;
            vld_q[0] <= issue;
            id_q[0]  <= gid;
            for (int k = LAT; k > 0; k--) begin
                vld_q[k] <= vld_q[k-1];
                id_q[k]  <= id_q[k-1];
            end
            if (issue) begin
                a_q    <= sel_a;
                b_q    <= sel_b;
                last_q <= gid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_q <= nxt(wr_q);
            if (pop) rd_q <= nxt(rd_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= {id_q[LAT], mul_product};
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && cnt_q == CW'(FIFO_DEPTH) && !pop));
    end
endmodule
